// File: rtl/axil_sram_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave.
// Contents: AXI response codes and the read/write channel FSM state types.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/axil_sram_if.sv
// AXI4-Lite bus bundle between a master and the SRAM slave.
// Channels: AR (arvalid/arready/araddr), R (rvalid/rready/rdata/rresp),
//           AW (awvalid/awready/awaddr), W (wvalid/wready/wdata/wstrb),
//           B (bvalid/bready/bresp).
// Modports: slave (memory side), master (requester side).
interface axil_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axil_sram_lat_counter.sv
// Response-latency down-counter, one per channel.
// Ports: clk, rst (sync, active-high), load (start a count), count (8-bit
//        cycles to wait), done (one-cycle pulse in the last wait cycle).
module lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] count,
    output logic       done
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = count;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with N on the accept edge, so the value 1 marks the N-th wait
    // cycle; the FSM leaves its wait state on the edge that ends it.
    assign done = (cnt_q == 8'd1);
endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite slave SRAM: DEPTH words of DATA_W bits with byte strobes,
// independent read and write channels and programmable response latency.
// Ports: clk, rst (sync, active-high), bus (axil_sram_if slave modport).
// All bus outputs are registered; out-of-range accesses answer SLVERR.
module axil_sram
    import axil_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 0,
    parameter int WRITE_LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    axil_sram_if.slave    bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (ADDR_W+1)'(addr >> OFF_W) < (ADDR_W+1)'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> OFF_W);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    // ---------------- read channel ----------------
    r_state_t          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlat_load, rlat_done, r_commit;
    logic [ADDR_W-1:0] r_addr;

    lat_counter u_rlat (
        .clk   (clk),
        .rst   (rst),
        .load  (rlat_load),
        .count (8'(READ_LAT)),
        .done  (rlat_done)
    );

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        ar_addr_d = ar_addr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlat_load = 1'b0;
        r_commit  = 1'b0;
        r_addr    = ar_addr_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (bus.arvalid && arready_q) begin
                    arready_d = 1'b0;
                    ar_addr_d = bus.araddr;
                    if (READ_LAT == 0) begin
                        r_commit = 1'b1;
                        r_addr   = bus.araddr;
                    end else begin
                        rlat_load = 1'b1;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rlat_done) begin
                    r_commit = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Memory is sampled on the edge rvalid rises; a write committing on
        // that same edge is not yet visible, so the read sees the old word.
        if (r_commit) begin
            rvalid_d  = 1'b1;
            r_state_d = R_RESP;
            if (in_range(r_addr)) begin
                rdata_d = mem_q[word_idx(r_addr)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
        if (rst) begin
            r_state_d = R_IDLE;
            arready_d = 1'b0;
            ar_addr_d = '0;
            rvalid_d  = 1'b0;
            rdata_d   = '0;
            rresp_d   = '0;
            rlat_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        r_state_q <= r_state_d;
        arready_q <= arready_d;
        ar_addr_q <= ar_addr_d;
        rvalid_q  <= rvalid_d;
        rdata_q   <= rdata_d;
        rresp_q   <= rresp_d;
    end

    // ---------------- write channel ----------------
    w_state_t          w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              wlat_load, wlat_done, w_commit;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [STRB_W-1:0] cur_strb;
    logic [STRB_W-1:0] mem_we;

    lat_counter u_wlat (
        .clk   (clk),
        .rst   (rst),
        .load  (wlat_load),
        .count (8'(WRITE_LAT)),
        .done  (wlat_done)
    );

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_addr_d = aw_addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wlat_load = 1'b0;
        w_commit  = 1'b0;
        mem_we    = '0;
        cur_addr  = aw_addr_q;
        cur_data  = wdata_q;
        cur_strb  = wstrb_q;
        unique case (w_state_q)
            W_IDLE: begin
                // Each ready stays high until its own channel is captured;
                // a handshake this cycle bypasses the holding register so a
                // zero-latency commit can use it immediately.
                awready_d = !aw_got_q;
                wready_d  = !w_got_q;
                if (bus.awvalid && awready_q) begin
                    awready_d = 1'b0;
                    aw_got_d  = 1'b1;
                    aw_addr_d = bus.awaddr;
                    cur_addr  = bus.awaddr;
                end
                if (bus.wvalid && wready_q) begin
                    wready_d = 1'b0;
                    w_got_d  = 1'b1;
                    wdata_d  = bus.wdata;
                    wstrb_d  = bus.wstrb;
                    cur_data = bus.wdata;
                    cur_strb = bus.wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (WRITE_LAT == 0) begin
                        w_commit = 1'b1;
                    end else begin
                        wlat_load = 1'b1;
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wlat_done) begin
                    w_commit = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_commit) begin
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
            if (in_range(cur_addr)) begin
                mem_we  = cur_strb;
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
        if (rst) begin
            w_state_d = W_IDLE;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            aw_got_d  = 1'b0;
            w_got_d   = 1'b0;
            aw_addr_d = '0;
            wdata_d   = '0;
            wstrb_d   = '0;
            bvalid_d  = 1'b0;
            bresp_d   = '0;
            wlat_load = 1'b0;
            mem_we    = '0;
        end
    end

    always_ff @(posedge clk) begin
        w_state_q <= w_state_d;
        awready_q <= awready_d;
        wready_q  <= wready_d;
        aw_got_q  <= aw_got_d;
        w_got_q   <= w_got_d;
        aw_addr_q <= aw_addr_d;
        wdata_q   <= wdata_d;
        wstrb_q   <= wstrb_d;
        bvalid_q  <= bvalid_d;
        bresp_q   <= bresp_d;
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (mem_we[b]) begin
                mem_q[word_idx(cur_addr)][b*8 +: 8] <= cur_data[b*8 +: 8];
            end
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axil_sram.sv
// Self-checking bench for axil_sram: directed cases plus randomized traffic
// checked against a byte-lane memory model kept in the bench.
module tb_axil_sram;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int DEPTH     = 64;
    localparam int READ_LAT  = 3;
    localparam int WRITE_LAT = 4;
    localparam int STRB_W    = DATA_W / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axil_sram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] model [DEPTH];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr / STRB_W) < DEPTH;
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [STRB_W-1:0] strb, input int aw_dly, input int w_dly,
                            input int hold, input int abort);
        int  cyc;
        int  n;
        bit  aw_done, w_done, hs_aw, hs_w, stable, seen;
        int  idx;
        logic [1:0] resp0;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            tick();
            cyc++;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("w_handshake_timeout", 64'(aw_done && w_done), 64'd1);
        if (abort >= 0) begin
            repeat (abort) tick();
            rst = 1'b1;
            tick();
            check("rst_ctrl_outs", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid,
                                         bus.bvalid, bus.rresp, bus.bresp}), 64'd0);
            check("rst_rdata", 64'(bus.rdata), 64'd0);
            rst = 1'b0;
            tick();
            check("rdy_after_abort", 64'({bus.arready, bus.awready, bus.wready}), 64'b111);
            seen = 0;
            repeat (8) begin
                if (bus.bvalid) seen = 1;
                tick();
            end
            check("no_bvalid_after_abort", 64'(seen), 64'd0);
            return;
        end
        n = 0;
        while (!bus.bvalid && n < 50) begin
            tick();
            n++;
        end
        check("b_latency", 64'(n), 64'(WRITE_LAT));
        check("bresp", 64'(bus.bresp), addr_ok(addr) ? 64'd0 : 64'd2);
        if (addr_ok(addr)) begin
            idx = int'(addr / STRB_W);
            for (int b = 0; b < STRB_W; b++) begin
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        if (hold > 0) begin
            resp0 = bus.bresp;
            stable = 1;
            bus.awvalid = 1'b1;
            repeat (hold) begin
                tick();
                if (!bus.bvalid || bus.bresp !== resp0 || bus.awready) stable = 0;
            end
            bus.awvalid = 1'b0;
            check("b_hold_stable", 64'(stable), 64'd1);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_drop_rdy", 64'({bus.bvalid, bus.awready, bus.wready}), 64'b011);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input int hold,
                           output logic [DATA_W-1:0] rd);
        int  cyc;
        int  n;
        bit  done, hs, stable;
        logic [DATA_W-1:0] exp_data, d0;
        done = 0; cyc = 0;
        exp_data = addr_ok(addr) ? model[addr / STRB_W] : '0;
        bus.araddr = addr;
        while (!done && cyc < 50) begin
            bus.arvalid = 1'b1;
            hs = bus.arready;
            tick();
            cyc++;
            if (hs) done = 1;
        end
        bus.arvalid = 1'b0;
        check("ar_handshake_timeout", 64'(done), 64'd1);
        n = 0;
        while (!bus.rvalid && n < 50) begin
            tick();
            n++;
        end
        check("r_latency", 64'(n), 64'(READ_LAT));
        check("rdata", 64'(bus.rdata), 64'(exp_data));
        check("rresp", 64'(bus.rresp), addr_ok(addr) ? 64'd0 : 64'd2);
        rd = bus.rdata;
        if (hold > 0) begin
            d0 = bus.rdata;
            stable = 1;
            bus.arvalid = 1'b1;
            repeat (hold) begin
                tick();
                if (!bus.rvalid || bus.rdata !== d0 || bus.arready) stable = 0;
            end
            bus.arvalid = 1'b0;
            check("r_hold_stable", 64'(stable), 64'd1);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("r_drop_rdy", 64'({bus.rvalid, bus.arready}), 64'b01);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [STRB_W-1:0] s;
        rst = 1'b1;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
        repeat (3) tick();
        check("reset_ctrl_outs", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid,
                                      bus.bvalid, bus.rresp, bus.bresp}), 64'd0);
        check("reset_rdata", 64'(bus.rdata), 64'd0);
        rst = 1'b0;
        tick();
        check("rdy_after_reset", 64'({bus.arready, bus.awready, bus.wready}), 64'b111);

        // give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            do_write(ADDR_W'(i * STRB_W), $urandom, '1, 0, 0, 0, -1);
        end

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, -1);
        do_read(32'h10, 0, rd);
        check("deadbeef", 64'(rd), 64'hDEADBEEF);

        // W three cycles ahead of AW, then AW ahead of W
        do_write(32'h24, 32'hCAFE0001, 4'hF, 3, 0, 0, -1);
        do_write(32'h28, 32'hCAFE0002, 4'hF, 0, 3, 0, -1);
        do_read(32'h24, 0, rd);
        check("w_first_data", 64'(rd), 64'hCAFE0001);
        do_read(32'h28, 0, rd);
        check("aw_first_data", 64'(rd), 64'hCAFE0002);

        do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0, -1);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0, -1);
        do_read(32'h20, 0, rd);
        check("strb_merge", 64'(rd), 64'h11BB33DD);

        do_write(32'h0, 32'h0BADF00D, 4'hF, 0, 0, 0, -1);
        do_read(ADDR_W'(DEPTH * 4), 0, rd);
        check("oor_rdata_zero", 64'(rd), 64'd0);
        do_write(ADDR_W'(DEPTH * 4), 32'h55555555, 4'hF, 0, 0, 0, -1);
        do_read(32'h0, 0, rd);
        check("word0_unchanged", 64'(rd), 64'h0BADF00D);

        do_read(32'h13, 0, rd);
        check("misaligned_read", 64'(rd), 64'hDEADBEEF);

        do_write(32'h30, 32'h12345678, 4'h0, 0, 0, 0, -1);
        do_read(32'h30, 0, rd);

        do_write(32'h34, 32'h87654321, 4'hF, 0, 0, 5, -1);
        do_read(32'h34, 5, rd);

        do_write(32'h38, 32'hFFFF0000, 4'hF, 0, 0, 0, -1);
        do_write(32'h38, 32'h0000FFFF, 4'hF, 0, 0, 0, 2);
        do_read(32'h38, 0, rd);
        check("abort_unchanged", 64'(rd), 64'hFFFF0000);

        for (int i = 0; i < 80; i++) begin
            a = ADDR_W'($urandom_range(0, DEPTH * STRB_W + 15));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = STRB_W'($urandom);
                do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)), -1);
            end else begin
                do_read(a, int'($urandom_range(0, 2)), rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
